imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 119 +++++++++++
 tb/tb_imem_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// UART program loader for the instruction RAM: owns the RAM write port during a
// download and muxes the CPU fetch path. While a load is in progress the CPU sees
// a nop and is held.
module imem_loader #(
  parameter int TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic [31:0] cpu_addr,
  output logic [31:0] cpu_instr,
  output logic        cpu_hold,
  output logic [7:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        load_done,
  output logic        load_error
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, HDR, DATA, CHK, FAIL} state_t;

  state_t          state, nstate;
  logic [7:0]      last_idx;
  logic [7:0]      widx;
  logic [7:0]      csum;
  logic [1:0]      bcnt;
  logic [23:0]     acc;
  logic [TW-1:0]   tcnt;
  logic            tmo;
  logic            word_done;
  logic            unused_addr;

  assign unused_addr = ^{cpu_addr[31:10], cpu_addr[1:0]};

  assign tmo       = !rx_valid && (tcnt == TW'(TIMEOUT - 1));
  assign word_done = (state == DATA) && rx_valid && (bcnt == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE: if (load_start) nstate = HDR;
      HDR: begin
        if (rx_valid)  nstate = DATA;
        else if (tmo)  nstate = FAIL;
      end
      DATA: begin
        if (word_done && (widx == last_idx)) nstate = CHK;
        else if (tmo)                        nstate = FAIL;
      end
      CHK: begin
        if (rx_valid)  nstate = (rx_data == csum) ? IDLE : FAIL;
        else if (tmo)  nstate = FAIL;
      end
      FAIL: if (load_start) nstate = HDR;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    cpu_hold   = (state != IDLE);
    load_error = (state == FAIL);
    rd_addr    = (state == IDLE) ? cpu_addr[9:2] : 8'd0;
    cpu_instr  = (state == IDLE) ? rd_data : 32'h0000_0000;
  end

  // Byte assembly, checksum, write port and inter-byte timeout
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en     <= 1'b0;
      wr_addr   <= 8'd0;
      wr_data   <= 32'd0;
      load_done <= 1'b0;
      last_idx  <= 8'd0;
      widx      <= 8'd0;
      csum      <= 8'd0;
      bcnt      <= 2'd0;
      acc       <= 24'd0;
      tcnt      <= '0;
    end else begin
      wr_en     <= word_done;
      load_done <= (state == CHK) && rx_valid && (rx_data == csum);

      if (state == HDR) begin
        widx <= 8'd0;
        csum <= 8'd0;
        bcnt <= 2'd0;
        // Header 0 wraps to 255, so a 256-word load ends at index 255
        if (rx_valid) last_idx <= rx_data - 8'd1;
      end

      if ((state == DATA) && rx_valid) begin
        acc  <= {acc[15:0], rx_data};
        csum <= csum ^ rx_data;
        bcnt <= bcnt + 2'd1;
      end

      if (word_done) begin
        wr_addr <= widx;
        wr_data <= {acc, rx_data};
        widx    <= widx + 8'd1;
      end

      if ((state == IDLE) || (state == FAIL) || rx_valid) tcnt <= '0;
      else                                                tcnt <= tcnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized downloads checked
// against a byte-stream model of the expected RAM writes and fetch results.
module tb_imem_loader;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic [31:0] cpu_addr = 32'd0;
  logic [31:0] cpu_instr;
  logic        cpu_hold;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        load_done;
  logic        load_error;

  always #5 clk = ~clk;

  imem_loader #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .rx_valid(rx_valid),
    .rx_data(rx_data), .cpu_addr(cpu_addr), .cpu_instr(cpu_instr),
    .cpu_hold(cpu_hold), .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .load_done(load_done),
    .load_error(load_error)
  );

  logic [31:0] ram   [256];
  logic [31:0] model [256];
  logic [39:0] wlog [$];
  logic [7:0]  data_q [$];
  int tests = 0;
  int fails = 0;

  assign rd_data = ram[rd_addr];

  always @(posedge clk) if (wr_en) ram[wr_addr] = wr_data;

  always @(negedge clk) if (wr_en) wlog.push_back({wr_addr, wr_data});

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic fetch_check(input int cnt);
    int idx;
    for (int k = 0; k < cnt; k++) begin
      idx = $urandom_range(0, 255);
      cpu_addr = {22'($urandom), idx[7:0], 2'($urandom)};
      #1;
      check("fetch_instr", 64'(cpu_instr), 64'(model[idx]));
      check("fetch_rd_addr", 64'(rd_addr), 64'(idx[7:0]));
    end
  endtask

  task automatic fill_random(input int n);
    data_q.delete();
    for (int i = 0; i < 4 * n; i++) data_q.push_back(8'($urandom));
  endtask

  // Full download of data_q as n words; checks hold/done/error and the write log
  task automatic run_load(input int n, input bit corrupt, input bit poke, input bit sw,
                          input int maxgap);
    logic [7:0]  cs;
    logic [31:0] w;
    int nw;
    cs = 8'd0;
    foreach (data_q[i]) cs ^= data_q[i];
    wlog.delete();
    load_start = 1'b1;
    rx_valid   = sw;
    rx_data    = 8'($urandom);
    @(negedge clk);
    load_start = 1'b0;
    rx_valid   = 1'b0;
    check("start_hold", 64'(cpu_hold), 64'(1));
    check("start_nop", 64'(cpu_instr), 64'(0));
    check("start_err_clear", 64'(load_error), 64'(0));
    send_byte(8'(n), $urandom_range(0, maxgap));
    foreach (data_q[i]) begin
      if (poke && i == 5) begin
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
      end
      if (poke && i == 6) load_start = 1'b1;
      send_byte(data_q[i], $urandom_range(0, maxgap));
      load_start = 1'b0;
    end
    send_byte(corrupt ? ~cs : cs, $urandom_range(0, maxgap));
    if (corrupt) begin
      check("bad_chk_err", 64'(load_error), 64'(1));
      check("bad_chk_hold", 64'(cpu_hold), 64'(1));
      check("bad_chk_nop", 64'(cpu_instr), 64'(0));
      check("bad_chk_done", 64'(load_done), 64'(0));
    end else begin
      check("done_pulse", 64'(load_done), 64'(1));
      check("done_hold", 64'(cpu_hold), 64'(0));
      check("done_err", 64'(load_error), 64'(0));
    end
    @(negedge clk);
    check("done_single", 64'(load_done), 64'(0));
    nw = data_q.size() / 4;
    check("wr_count", 64'(wlog.size()), 64'(nw));
    for (int i = 0; i < nw; i++) begin
      w = {data_q[4*i], data_q[4*i+1], data_q[4*i+2], data_q[4*i+3]};
      model[i] = w;
      if (i < wlog.size()) check("wr_log", 64'(wlog[i]), 64'({i[7:0], w}));
    end
    if (!corrupt) fetch_check(4);
  endtask

  initial begin
    int k;
    logic [31:0] w0;
    for (int i = 0; i < 256; i++) begin
      ram[i]   = $urandom;
      model[i] = ram[i];
    end
    cpu_addr = 32'h0000_0010;
    #12;
    check("rst_hold", 64'(cpu_hold), 64'(0));
    check("rst_wr_en", 64'(wr_en), 64'(0));
    check("rst_done", 64'(load_done), 64'(0));
    check("rst_err", 64'(load_error), 64'(0));
    check("rst_wr_addr", 64'(wr_addr), 64'(0));
    check("rst_wr_data", 64'(wr_data), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Bytes while idle are ignored
    repeat (3) send_byte(8'($urandom), 1);
    @(negedge clk);
    check("idle_rx_writes", 64'(wlog.size()), 64'(0));
    check("idle_rx_hold", 64'(cpu_hold), 64'(0));
    fetch_check(3);

    // Directed two-word load, then fetch of word 1
    data_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load(2, 1'b0, 1'b0, 1'b0, 0);
    cpu_addr = 32'h0000_0004;
    #1;
    check("dir_fetch4", 64'(cpu_instr), 64'(32'hAABBCCDD));
    @(negedge clk);

    // Same stream with a bad checksum ends in FAIL; words stay written
    run_load(2, 1'b1, 1'b0, 1'b0, 0);
    check("fail_ram0_kept", 64'(ram[0]), 64'(32'h11223344));

    // Recovery from FAIL with a random load
    fill_random(3);
    run_load(3, 1'b0, 1'b0, 1'b0, 2);

    // Inter-byte timeout: header 01, two bytes, then silence
    wlog.delete();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    send_byte(8'h01, 0);
    send_byte(8'($urandom), 0);
    send_byte(8'($urandom), 0);
    k = 0;
    while (!load_error && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("timeout_cycles", 64'(k), 64'(TMO));
    check("timeout_hold", 64'(cpu_hold), 64'(1));
    repeat (3) @(negedge clk);
    check("timeout_no_write", 64'(wlog.size()), 64'(0));

    // 256-word load with an incrementing pattern
    data_q.delete();
    for (int i = 0; i < 1024; i++) data_q.push_back(i[7:0]);
    run_load(256, 1'b0, 1'b0, 1'b0, 0);

    // Randomized loads; some with load_start noise or a start+byte collision
    for (int r = 0; r < 6; r++) begin
      fill_random($urandom_range(1, 8));
      run_load(data_q.size() / 4, 1'b0, r == 2, r == 3, 3);
    end
    fill_random(2);
    run_load(2, 1'b1, 1'b1, 1'b0, 1);
    fill_random(4);
    run_load(4, 1'b0, 1'b0, 1'b1, 1);

    // Reset between 2nd and 3rd byte of word 1
    fill_random(2);
    wlog.delete();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    send_byte(8'h02, 0);
    for (int i = 0; i < 6; i++) send_byte(data_q[i], 0);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_hold", 64'(cpu_hold), 64'(0));
    check("midrst_wr_en", 64'(wr_en), 64'(0));
    check("midrst_wr_addr", 64'(wr_addr), 64'(0));
    check("midrst_err", 64'(load_error), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_wr_en_hold", 64'(wr_en), 64'(0));
    end
    reset = 1'b1;
    send_byte(data_q[6], 1);
    send_byte(data_q[7], 1);
    repeat (2) @(negedge clk);
    w0 = {data_q[0], data_q[1], data_q[2], data_q[3]};
    model[0] = w0;
    check("midrst_wr_count", 64'(wlog.size()), 64'(1));
    if (wlog.size() > 0) check("midrst_word0", 64'(wlog[0]), 64'({8'd0, w0}));
    check("midrst_idle_hold", 64'(cpu_hold), 64'(0));
    fetch_check(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
